// File: rtl/smoldvi_pkg.sv
`default_nettype none
// ============================================================================
// smoldvi_pkg -- shared pattern-mode encodings for the smoldvi video blocks
// Rev 1.0
// ============================================================================
package smoldvi_pkg;

    typedef enum logic [1:0] {
        MODE_GRADIENT = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_SOLID    = 2'd3
    } mode_e;

    localparam int FRAME_W = 8;

endpackage
`default_nettype wire

// File: rtl/smoldvi_raster_ctr.sv
`default_nettype none
// ============================================================================
// smoldvi_raster_ctr -- pixel position / frame counter advanced on consume
// Rev 1.0
// ============================================================================
module smoldvi_raster_ctr
    import smoldvi_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int W_X      = $clog2(H_ACTIVE),
    parameter int W_Y      = $clog2(V_ACTIVE)
) (
    input  logic               clk_pix,
    input  logic               rst_n_pix,
    input  logic               en,
    input  logic               rgb_rdy,
    output logic [W_X-1:0]     x,
    output logic [W_Y-1:0]     y,
    output logic [FRAME_W-1:0] frame,
    output logic               sof,
    output logic               eol,
    output logic               frame_wrap
);

    logic [W_X-1:0]     r_x;
    logic [W_Y-1:0]     r_y;
    logic [FRAME_W-1:0] r_frame;
    logic               w_consume;
    logic               w_eol;
    logic               w_last_line;

    assign w_consume   = en && rgb_rdy;
    assign w_eol       = (r_x == W_X'(H_ACTIVE - 1));
    assign w_last_line = (r_y == W_Y'(V_ACTIVE - 1));

    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            r_x     <= '0;
            r_y     <= '0;
            r_frame <= '0;
        end else if (!en) begin
            // Disabled: park at the top-left pixel but keep the frame count.
            r_x <= '0;
            r_y <= '0;
        end else if (rgb_rdy) begin
            if (w_eol) begin
                r_x <= '0;
                if (w_last_line) begin
                    r_y     <= '0;
                    r_frame <= r_frame + FRAME_W'(1);
                end else begin
                    r_y <= r_y + W_Y'(1);
                end
            end else begin
                r_x <= r_x + W_X'(1);
            end
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign frame      = r_frame;
    assign sof        = (r_x == '0) && (r_y == '0);
    assign eol        = w_eol;
    assign frame_wrap = w_consume && w_eol && w_last_line;

endmodule
`default_nettype wire

// File: rtl/smoldvi_pattern_gen.sv
`default_nettype none
// ============================================================================
// smoldvi_pattern_gen -- test-pattern source (gradient/bars/checker/solid)
// Rev 1.0
// ============================================================================
module smoldvi_pattern_gen
    import smoldvi_pkg::*;
#(
    parameter int  H_ACTIVE   = 640,
    parameter int  V_ACTIVE   = 480,
    parameter int  CHECK_LOG2 = 4,
    localparam int W_X        = $clog2(H_ACTIVE),
    localparam int W_Y        = $clog2(V_ACTIVE)
) (
    input  logic               clk_pix,
    input  logic               rst_n_pix,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [23:0]        solid_rgb,
    input  logic               rgb_rdy,
    output logic [7:0]         r,
    output logic [7:0]         g,
    output logic [7:0]         b,
    output logic [W_X-1:0]     x,
    output logic [W_Y-1:0]     y,
    output logic [FRAME_W-1:0] frame,
    output logic               sof,
    output logic               eol
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int W_BAR = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic             w_frame_wrap;
    logic             w_consume;
    mode_e            r_mode_q;
    logic [W_BAR-1:0] r_bar_cnt;
    logic [2:0]       r_bar_idx;

    smoldvi_raster_ctr #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .W_X      (W_X),
        .W_Y      (W_Y)
    ) u_raster (
        .clk_pix    (clk_pix),
        .rst_n_pix  (rst_n_pix),
        .en         (en),
        .rgb_rdy    (rgb_rdy),
        .x          (x),
        .y          (y),
        .frame      (frame),
        .sof        (sof),
        .eol        (eol),
        .frame_wrap (w_frame_wrap)
    );

    assign w_consume = en && rgb_rdy;

    // Mode only changes when the next current pixel is (0,0).
    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            r_mode_q <= MODE_GRADIENT;
        end else if (!en || w_frame_wrap) begin
            r_mode_q <= mode_e'(mode);
        end
    end

    // Bar index tracks x without a divider: count BAR_W pixels per bar.
    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (!en) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (w_consume) begin
            if (eol) begin
                r_bar_cnt <= '0;
                r_bar_idx <= '0;
            end else if (r_bar_cnt == W_BAR'(BAR_W - 1)) begin
                r_bar_cnt <= '0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_cnt <= r_bar_cnt + W_BAR'(1);
            end
        end
    end

    logic [7:0] w_x8;
    logic [7:0] w_y8;
    logic [7:0] w_chk_sum;
    logic       w_chk;
    logic [2:0] w_bar_c;

    assign w_x8      = 8'(x);
    assign w_y8      = 8'(y);
    assign w_chk_sum = w_x8 + frame;
    assign w_chk     = w_chk_sum[CHECK_LOG2] ^ w_y8[CHECK_LOG2];
    assign w_bar_c   = 3'd7 - r_bar_idx;

    always_comb begin
        r = 8'h00;
        g = 8'h00;
        b = 8'h00;
        if (en) begin
            case (r_mode_q)
                MODE_GRADIENT: begin
                    r = w_x8 + frame;
                    g = w_y8 + {frame[6:0], 1'b0};
                    b = frame;
                end
                MODE_BARS: begin
                    r = {8{w_bar_c[1]}};
                    g = {8{w_bar_c[2]}};
                    b = {8{w_bar_c[0]}};
                end
                MODE_CHECKER: begin
                    r = {8{w_chk}};
                    g = {8{w_chk}};
                    b = {8{w_chk}};
                end
                default: begin
                    r = solid_rgb[23:16];
                    g = solid_rgb[15:8];
                    b = solid_rgb[7:0];
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_smoldvi_pattern_gen.sv
`default_nettype none
// ============================================================================
// tb_smoldvi_pattern_gen -- directed + randomized bench against a raster model
// Rev 1.0
// ============================================================================
module tb_smoldvi_pattern_gen;

    localparam int H  = 640;
    localparam int V  = 6;
    localparam int CL = 2;
    localparam int WX = $clog2(H);
    localparam int WY = $clog2(V);

    logic          clk_pix = 1'b0;
    logic          rst_n_pix;
    logic          en;
    logic [1:0]    mode;
    logic [23:0]   solid_rgb;
    logic          rgb_rdy;
    logic [7:0]    r, g, b;
    logic [WX-1:0] x;
    logic [WY-1:0] y;
    logic [7:0]    frame;
    logic          sof, eol;

    smoldvi_pattern_gen #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .CHECK_LOG2 (CL)
    ) dut (
        .clk_pix   (clk_pix),
        .rst_n_pix (rst_n_pix),
        .en        (en),
        .mode      (mode),
        .solid_rgb (solid_rgb),
        .rgb_rdy   (rgb_rdy),
        .r         (r),
        .g         (g),
        .b         (b),
        .x         (x),
        .y         (y),
        .frame     (frame),
        .sof       (sof),
        .eol       (eol)
    );

    always #5 clk_pix = ~clk_pix;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: position, frame and the mode the current frame uses.
    int mx, my, mf, mm;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [23:0] exp_rgb();
        int c;
        int p;
        if (!en) return 24'h0;
        case (mm)
            0: return {8'(mx + mf), 8'(my + 2 * mf), 8'(mf)};
            1: begin
                c = 7 - mx / (H / 8);
                return {{8{c[1]}}, {8{c[2]}}, {8{c[0]}}};
            end
            2: begin
                p = (((mx + mf) >> CL) & 1) ^ ((my >> CL) & 1);
                return (p != 0) ? 24'hFFFFFF : 24'h000000;
            end
            default: return solid_rgb;
        endcase
    endfunction

    task automatic check_all(input string tag);
        cmp({tag, ".x"},     32'(x),         32'(mx));
        cmp({tag, ".y"},     32'(y),         32'(my));
        cmp({tag, ".frame"}, 32'(frame),     32'(mf));
        cmp({tag, ".rgb"},   32'({r, g, b}), 32'(exp_rgb()));
        cmp({tag, ".sof"},   32'(sof),       32'((mx == 0) && (my == 0)));
        cmp({tag, ".eol"},   32'(eol),       32'(mx == H - 1));
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mf = 0; mm = 0;
    endtask

    task automatic tick(input bit rdy, input string tag);
        rgb_rdy = rdy;
        @(posedge clk_pix);
        if (!en) begin
            mx = 0; my = 0; mm = int'(mode);
        end else if (rdy) begin
            if (mx == H - 1) begin
                mx = 0;
                if (my == V - 1) begin
                    my = 0;
                    mf = (mf + 1) % 256;
                    mm = int'(mode);
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic run_to(input int tx, input int ty, input string tag);
        int n = 0;
        while (!(mx == tx && my == ty) && n < 20000) begin
            tick(1'b1, tag);
            n++;
        end
        cmp({tag, ".bound"}, 32'(n < 20000), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] prev_rgb;
        int          prev_x;
        int          saved_f;
        int          n;

        rst_n_pix = 1'b0;
        en        = 1'b1;
        mode      = 2'd0;
        rgb_rdy   = 1'b1;
        solid_rgb = 24'($urandom);
        model_reset();
        repeat (3) @(posedge clk_pix);
        #1;
        check_all("reset");
        cmp("reset.rgb_zero", 32'({r, g, b}), 32'd0);
        @(negedge clk_pix);
        rst_n_pix = 1'b1;
        #1;
        check_all("release");

        // One full frame of continuous consumption.
        for (int i = 0; i < H * V; i++) tick(1'b1, "frame_run");
        cmp("frame_end.x", 32'(x), 32'd0);
        cmp("frame_end.frame", 32'(frame), 32'd1);
        cmp("frame_end.sof", 32'(sof), 32'd1);
        cmp("frame_end.rgb", 32'({r, g, b}), 32'h010201);

        // Colour bars over one line.
        mode = 2'd1;
        en   = 1'b0;
        tick(1'b1, "bars_dis");
        tick(1'b1, "bars_dis");
        en = 1'b1;
        #1;
        cmp("bars.x0", 32'({r, g, b}), 32'hFFFFFF);
        for (int i = 0; i < H; i++) begin
            tick(1'b1, "bars");
            if (mx == 79)  cmp("bars.x79",  32'({r, g, b}), 32'hFFFFFF);
            if (mx == 80)  cmp("bars.x80",  32'({r, g, b}), 32'hFFFF00);
            if (mx == 560) cmp("bars.x560", 32'({r, g, b}), 32'h000000);
            if (mx == 639) cmp("bars.x639", 32'({r, g, b, 7'd0, eol}), {24'h000000, 8'h01});
        end

        // Random back-pressure, modes and solid colour.
        for (int i = 0; i < 4000; i++) begin
            bit rdy;
            rdy = 1'($urandom_range(0, 1));
            if (i % 50 == 0) mode = 2'($urandom_range(0, 3));
            if (rdy && (i % 7 == 0)) solid_rgb = 24'($urandom);
            prev_rgb = {r, g, b};
            prev_x   = int'(x);
            tick(rdy, "rand");
            if (!rdy) begin
                cmp("rand.hold_x",   32'(x),         32'(prev_x));
                cmp("rand.hold_rgb", 32'({r, g, b}), 32'(prev_rgb));
            end
        end

        // Enable dropped mid-frame for five cycles.
        run_to(300, 2, "en_pre");
        saved_f = mf;
        mode    = 2'd1;
        en      = 1'b0;
        #1;
        cmp("en_low.rgb_comb", 32'({r, g, b}), 32'd0);
        repeat (5) tick(1'b1, "en_low");
        en = 1'b1;
        #1;
        cmp("en_back.x", 32'(x), 32'd0);
        cmp("en_back.y", 32'(y), 32'd0);
        cmp("en_back.frame", 32'(frame), 32'(saved_f));
        cmp("en_back.mode_bars", 32'({r, g, b}), 32'hFFFFFF);
        tick(1'b1, "en_back");

        // Asynchronous reset in the last line.
        mode = 2'd0;
        run_to(500, V - 1, "arst_pre");
        #2;
        rst_n_pix = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        @(posedge clk_pix);
        #1;
        check_all("arst_hold");
        @(negedge clk_pix);
        rst_n_pix = 1'b1;
        #1;
        cmp("arst_rel.frame", 32'(frame), 32'd0);
        check_all("arst_rel");

        // Mid-frame mode switch takes effect only at the next frame.
        run_to(100, 3, "sw_pre");
        mode = 2'd2;
        n = 0;
        do begin
            tick(1'b1, "sw_wait");
            n++;
        end while (!(mx == 0 && my == 0) && n < 10000);
        cmp("sw.bound", 32'(n < 10000), 32'd1);
        cmp("sw.frame", 32'(frame), 32'd1);
        cmp("sw.checker00", 32'({r, g, b}), 32'd0);
        for (int i = 0; i < 8; i++) tick(1'b1, "sw_chk");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smoldvi_pattern_gen.md
SMOLDVI_PATTERN_GEN -- requirements
Module: smoldvi_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame; at least 2.
REQ-003 Parameter CHECK_LOG2, default 4, log2 of checkerboard cell size in pixels; range 0..7.
REQ-004 Derived widths: W_X = clog2(H_ACTIVE), W_Y = clog2(V_ACTIVE); frame counter width fixed at 8.
REQ-005 clk_pix  in  1  pixel clock; the block's only clock.
REQ-006 rst_n_pix  in  1  reset, asynchronous assert, active-low.
REQ-007 en  in  1  generator enable.
REQ-008 mode  in  2  requested pattern: 0 GRADIENT, 1 BARS, 2 CHECKER, 3 SOLID.
REQ-009 solid_rgb  in  24  SOLID colour, {r[23:16], g[15:8], b[7:0]}.
REQ-010 rgb_rdy  in  1  sink consumes the current pixel at this clock edge.
REQ-011 r, g, b  out  8 each  current pixel colour.
REQ-012 x  out  W_X, y  out  W_Y, frame  out  8: current pixel coordinates and frame count.
REQ-013 sof  out  1  high while current pixel is (0,0); eol  out  1  high while x == H_ACTIVE-1.

Function
REQ-014 Pixel is always presented; it is consumed on any clk_pix edge where en && rgb_rdy; no other event advances state.
REQ-015 On consume: x increments; at x == H_ACTIVE-1, x wraps to 0 and y increments; at y == V_ACTIVE-1 also, y wraps to 0 and frame increments modulo 256.
REQ-016 rgb_rdy low: x, y, frame, bar state and colour outputs hold.
REQ-017 en low: x, y, bar state clear to 0 on next edge; frame holds; r, g, b forced to 0 combinationally.
REQ-018 Pattern select mode_q is loaded from mode only when the (0,0) pixel becomes current: at reset release, on frame wrap consume, or while en low; mode changes mid-frame have no effect until next frame.
REQ-019 r, g, b, sof, eol are combinational functions of registered state (x, y, frame, mode_q, bar state) and solid_rgb; zero-cycle latency from state.
REQ-020 GRADIENT: r = x[7:0] + frame, g = y[7:0] + 2*frame, b = frame, all modulo 256.
REQ-021 BARS: bar_idx 0..7 advances every H_ACTIVE/8 consumed pixels via an internal within-bar counter (no divider), clears on line wrap; c = 7 - bar_idx; g = {8{c[2]}}, r = {8{c[1]}}, b = {8{c[0]}} (white, yellow, cyan, green, magenta, red, blue, black).
REQ-022 CHECKER: p = (x + frame)[CHECK_LOG2] XOR y[CHECK_LOG2]; r = g = b = p ? 8'hFF : 8'h00 (scrolls one pixel per frame).
REQ-023 SOLID: r, g, b taken from solid_rgb live (not latched).
REQ-024 Bar state advances only on consume, in lockstep with x, whatever mode_q is.

Reset
REQ-025 Asserted rst_n_pix: x = 0, y = 0, frame = 0, bar_idx = 0, within-bar counter = 0, mode_q = 0 (GRADIENT).
REQ-026 Consequent output values in reset with en high: r = g = b = 0, sof = 1, eol = 0.
REQ-027 Reset mid-line/mid-frame discards position; first pixel after release is (0,0) of frame 0.

Structure
REQ-028 Mode encodings (MODE_GRADIENT, MODE_BARS, MODE_CHECKER, MODE_SOLID) live in shared package smoldvi_pkg.
REQ-029 Coordinate/frame counting in sub-module smoldvi_raster_ctr (x, y, frame, sof, eol, wrap strobe); colour logic in the parent.
REQ-030 No clock division, no second clock, no memory.

Verification
REQ-031 Reset, en=1, rgb_rdy=1 constant, mode=0: after exactly 307200 edges, x=0, y=0, frame=1, sof=1, and r=1, g=2, b=1.
REQ-032 mode=1, H_ACTIVE=640: pixel at x=0 -> FF/FF/FF; x=79 -> white; x=80 -> r=FF, g=FF, b=00; x=560 -> 00/00/00; x=639 black, eol=1.
REQ-033 mode switched 0->2 at x=100, y=10: colours stay GRADIENT until frame wraps; first (0,0) of next frame shows CHECKER with frame=1 -> p = 0 -> 00.
REQ-034 rgb_rdy toggled pseudo-randomly 50%: x, y, r, g, b stable across every non-consume edge; sequence of consumed pixels identical to continuous run.
REQ-035 en dropped at x=300, y=200 for 5 cycles: r=g=b=0 during; after re-enable x=0, y=0, frame unchanged, mode_q = current mode.
REQ-036 rst_n_pix asserted asynchronously at x=500, y=479: outputs return to REQ-025/026 values before next edge; frame=0 after release.
